// File: rtl/bitwise_op_scheduler_pkg.sv
// Shared constants for the bitwise op scheduler:
// logic-unit opcodes and scheduler FSM states.
package bitwise_op_scheduler_pkg;

  localparam logic [2:0] OP_AND   = 3'd0;
  localparam logic [2:0] OP_OR    = 3'd1;
  localparam logic [2:0] OP_XOR   = 3'd2;
  localparam logic [2:0] OP_XNOR  = 3'd3;
  localparam logic [2:0] OP_NOTA  = 3'd4;
  localparam logic [2:0] OP_NAND  = 3'd5;
  localparam logic [2:0] OP_NOR   = 3'd6;
  localparam logic [2:0] OP_PASSA = 3'd7;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_e;

endpackage

// File: rtl/bitwise_alu.sv
// Combinational DATA_W-wide bitwise logic unit.
// NOT A and PASS A ignore operand b.
module bitwise_alu
  import bitwise_op_scheduler_pkg::*;
#(
  parameter int DATA_W = 8
) (
  input  logic [2:0]        op,
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  output logic [DATA_W-1:0] y
);

  // Opcode decode into one bitwise function
  always_comb begin
    y = '0;
    unique case (op)
      OP_AND:   y = a & b;
      OP_OR:    y = a | b;
      OP_XOR:   y = a ^ b;
      OP_XNOR:  y = ~(a ^ b);
      OP_NOTA:  y = ~a;
      OP_NAND:  y = ~(a & b);
      OP_NOR:   y = ~(a | b);
      OP_PASSA: y = a;
      default:  y = '0;
    endcase
  end

endmodule

// File: rtl/bitwise_op_scheduler.sv
// Round-robin scheduler sharing one bitwise logic
// unit among NUM_REQ requesters, one op in flight.
module bitwise_op_scheduler
  import bitwise_op_scheduler_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int DATA_W  = 8,
  parameter int ID_W    = 2
) (
  input  logic                      clk_in,
  input  logic                      rst_n_in,
  input  logic [NUM_REQ-1:0]        req_in,
  input  logic [3*NUM_REQ-1:0]      op_in,
  input  logic [DATA_W*NUM_REQ-1:0] a_in,
  input  logic [DATA_W*NUM_REQ-1:0] b_in,
  output logic [NUM_REQ-1:0]        gnt_out,
  output logic                      res_valid_out,
  input  logic                      res_ready_in,
  output logic [DATA_W-1:0]         res_data_out,
  output logic [ID_W-1:0]           res_id_out,
  output logic                      busy_out,
  output logic [15:0]               op_cnt_out
);

  state_e              state_q, state_d;
  logic [ID_W-1:0]     ptr_q, ptr_d;
  logic [ID_W-1:0]     id_q, id_d;
  logic [ID_W-1:0]     rid_q, rid_d;
  logic [2:0]          op_q, op_d;
  logic [DATA_W-1:0]   a_q, a_d;
  logic [DATA_W-1:0]   b_q, b_d;
  logic [NUM_REQ-1:0]  gnt_q, gnt_d;
  logic                vld_q, vld_d;
  logic [DATA_W-1:0]   res_q, res_d;
  logic [15:0]         cnt_q, cnt_d;

  logic                found;
  logic [ID_W-1:0]     win;
  logic [ID_W:0]       sum;
  logic [2:0]          op_sel;
  logic [DATA_W-1:0]   a_sel;
  logic [DATA_W-1:0]   b_sel;
  logic [DATA_W-1:0]   alu_y;

  bitwise_alu #(
    .DATA_W (DATA_W)
  ) u_alu (
    .op (op_q),
    .a  (a_q),
    .b  (b_q),
    .y  (alu_y)
  );

  // First set request at or above the pointer, wrapping
  always_comb begin
    found = 1'b0;
    win   = '0;
    sum   = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      sum = {1'b0, ptr_q} + (ID_W+1)'(k);
      if (sum >= (ID_W+1)'(NUM_REQ))
        sum = sum - (ID_W+1)'(NUM_REQ);
      if (!found && req_in[sum[ID_W-1:0]]) begin
        found = 1'b1;
        win   = sum[ID_W-1:0];
      end
    end
  end

  // Select the winner's opcode and operand slices
  always_comb begin
    op_sel = '0;
    a_sel  = '0;
    b_sel  = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (win == ID_W'(i)) begin
        op_sel = op_in[3*i +: 3];
        a_sel  = a_in[DATA_W*i +: DATA_W];
        b_sel  = b_in[DATA_W*i +: DATA_W];
      end
    end
  end

  // Next-state and next-output computation
  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    id_d    = id_q;
    rid_d   = rid_q;
    op_d    = op_q;
    a_d     = a_q;
    b_d     = b_q;
    gnt_d   = '0;
    vld_d   = vld_q;
    res_d   = res_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      IDLE: begin
        if (found) begin
          gnt_d   = NUM_REQ'(1) << win;
          op_d    = op_sel;
          a_d     = a_sel;
          b_d     = b_sel;
          id_d    = win;
          ptr_d   = (win == ID_W'(NUM_REQ-1))
                    ? '0 : win + ID_W'(1);
          state_d = EXEC;
        end
      end
      EXEC: begin
        res_d   = alu_y;
        rid_d   = id_q;
        vld_d   = 1'b1;
        state_d = RESP;
      end
      RESP: begin
        if (res_ready_in) begin
          vld_d   = 1'b0;
          cnt_d   = cnt_q + 16'd1;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State and registered outputs; reset drops any op
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      state_q <= IDLE;
      ptr_q   <= '0;
      id_q    <= '0;
      rid_q   <= '0;
      op_q    <= '0;
      a_q     <= '0;
      b_q     <= '0;
      gnt_q   <= '0;
      vld_q   <= 1'b0;
      res_q   <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      id_q    <= id_d;
      rid_q   <= rid_d;
      op_q    <= op_d;
      a_q     <= a_d;
      b_q     <= b_d;
      gnt_q   <= gnt_d;
      vld_q   <= vld_d;
      res_q   <= res_d;
      cnt_q   <= cnt_d;
    end
  end

  assign gnt_out       = gnt_q;
  assign res_valid_out = vld_q;
  assign res_data_out  = res_q;
  assign res_id_out    = rid_q;
  assign busy_out      = (state_q != IDLE);
  assign op_cnt_out    = cnt_q;

endmodule

// File: tb/tb_bitwise_op_scheduler.sv
// Directed self-checking bench for the
// bitwise op scheduler (NUM_REQ=4, DATA_W=8).
module tb_bitwise_op_scheduler;

  logic        clk;
  logic        rst_n;
  logic [3:0]  req;
  logic [11:0] op;
  logic [31:0] a;
  logic [31:0] b;
  logic [3:0]  gnt;
  logic        vld;
  logic        rdy;
  logic [7:0]  data;
  logic [1:0]  id;
  logic        busy;
  logic [15:0] cnt;

  int n_chk  = 0;
  int n_pass = 0;

  bitwise_op_scheduler #(
    .NUM_REQ (4),
    .DATA_W  (8),
    .ID_W    (2)
  ) dut (
    .clk_in        (clk),
    .rst_n_in      (rst_n),
    .req_in        (req),
    .op_in         (op),
    .a_in          (a),
    .b_in          (b),
    .gnt_out       (gnt),
    .res_valid_out (vld),
    .res_ready_in  (rdy),
    .res_data_out  (data),
    .res_id_out    (id),
    .busy_out      (busy),
    .op_cnt_out    (cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: time limit hit");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h want %0h",
                  tag, got, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic lane(input int i,
                      input logic [2:0] o,
                      input logic [7:0] av,
                      input logic [7:0] bv);
    op[3*i +: 3] = o;
    a[8*i +: 8]  = av;
    b[8*i +: 8]  = bv;
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_gnt"},  32'(gnt),  32'h0);
    chk({tag, "_vld"},  32'(vld),  32'h0);
    chk({tag, "_data"}, 32'(data), 32'h0);
    chk({tag, "_id"},   32'(id),   32'h0);
    chk({tag, "_busy"}, 32'(busy), 32'h0);
    chk({tag, "_cnt"},  32'(cnt),  32'h0);
  endtask

  logic [7:0] sw_exp [8] = '{8'h05, 8'hAF, 8'hAA, 8'h55,
                             8'h5A, 8'hFA, 8'h50, 8'hA5};
  logic [7:0] fa     [4] = '{8'h11, 8'h22, 8'h44, 8'h88};
  logic [7:0] fa_exp [4] = '{8'hEE, 8'hDD, 8'hBB, 8'h77};
  logic [3:0] oh     [4] = '{4'b0001, 4'b0010,
                             4'b0100, 4'b1000};

  initial begin
    rst_n = 1'b0;
    req   = '0;
    op    = '0;
    a     = '0;
    b     = '0;
    rdy   = 1'b1;
    tick();
    tick();
    chk_zero("reset");
    rst_n = 1'b1;

    // single request
    lane(0, 3'd0, 8'hF0, 8'h3C);
    req = 4'b0001;
    tick();
    chk("single_gnt", 32'(gnt), 32'h1);
    chk("single_busy", 32'(busy), 32'h1);
    chk("single_vld0", 32'(vld), 32'h0);
    req = 4'b0000;
    tick();
    chk("single_vld", 32'(vld), 32'h1);
    chk("single_data", 32'(data), 32'h30);
    chk("single_id", 32'(id), 32'h0);
    chk("single_gnt0", 32'(gnt), 32'h0);
    tick();
    chk("single_done", 32'(vld), 32'h0);
    chk("single_cnt", 32'(cnt), 32'h1);

    // opcode sweep on requester 2
    for (int k = 0; k < 8; k++) begin
      lane(2, 3'(k), 8'hA5, 8'h0F);
      req = 4'b0100;
      tick();
      chk("sweep_gnt", 32'(gnt), 32'h4);
      req = 4'b0000;
      tick();
      chk($sformatf("sweep_op%0d", k),
          32'(data), 32'(sw_exp[k]));
      chk("sweep_id", 32'(id), 32'h2);
      tick();
    end
    chk("sweep_cnt", 32'(cnt), 32'd9);

    // requester 3 alone leaves the pointer at 0
    lane(3, 3'd7, 8'h3C, 8'h00);
    req = 4'b1000;
    tick();
    chk("r3_gnt", 32'(gnt), 32'h8);
    req = 4'b0000;
    tick();
    chk("r3_data", 32'(data), 32'h3C);
    chk("r3_id", 32'(id), 32'h3);
    tick();

    // fairness with all requests held
    for (int i = 0; i < 4; i++)
      lane(i, 3'd2, fa[i], 8'hFF);
    req = 4'b1111;
    for (int k = 0; k < 6; k++) begin
      tick();
      chk($sformatf("fair_gnt%0d", k),
          32'(gnt), 32'(oh[k%4]));
      tick();
      chk("fair_gap", 32'(gnt), 32'h0);
      chk("fair_id", 32'(id), 32'(k%4));
      chk("fair_data", 32'(data), 32'(fa_exp[k%4]));
      tick();
      chk("fair_idle", 32'(busy), 32'h0);
    end
    req = 4'b0000;
    chk("fair_cnt", 32'(cnt), 32'd16);

    // backpressure while requester 1 waits
    lane(0, 3'd0, 8'hFF, 8'h81);
    lane(1, 3'd1, 8'h12, 8'h40);
    rdy = 1'b0;
    req = 4'b0001;
    tick();
    chk("bp_gnt0", 32'(gnt), 32'h1);
    req = 4'b0010;
    tick();
    chk("bp_vld", 32'(vld), 32'h1);
    for (int k = 0; k < 5; k++) begin
      tick();
      chk("bp_hold_vld", 32'(vld), 32'h1);
      chk("bp_hold_data", 32'(data), 32'h81);
      chk("bp_hold_id", 32'(id), 32'h0);
      chk("bp_hold_gnt", 32'(gnt), 32'h0);
      chk("bp_hold_busy", 32'(busy), 32'h1);
    end
    rdy = 1'b1;
    tick();
    chk("bp_hs_vld", 32'(vld), 32'h0);
    chk("bp_hs_busy", 32'(busy), 32'h0);
    chk("bp_hs_gnt", 32'(gnt), 32'h0);
    tick();
    chk("bp_gnt1", 32'(gnt), 32'h2);
    req = 4'b0000;
    tick();
    chk("bp_data1", 32'(data), 32'h52);
    chk("bp_id1", 32'(id), 32'h1);
    tick();
    chk("bp_cnt", 32'(cnt), 32'd18);

    // reset during the grant cycle
    lane(2, 3'd0, 8'hFF, 8'hFF);
    req = 4'b0100;
    tick();
    chk("rst_pre_gnt", 32'(gnt), 32'h4);
    rst_n = 1'b0;
    #1;
    chk_zero("rst_exec");
    tick();
    chk("rst_no_res", 32'(vld), 32'h0);
    rst_n = 1'b1;
    lane(0, 3'd0, 8'hF0, 8'h3C);
    lane(3, 3'd7, 8'h99, 8'h00);
    req = 4'b1001;
    tick();
    chk("rst_ptr_gnt", 32'(gnt), 32'h1);
    req = 4'b0000;
    tick();
    chk("rst_data", 32'(data), 32'h30);
    chk("rst_id", 32'(id), 32'h0);
    tick();
    chk("rst_cnt", 32'(cnt), 32'h1);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
